pipe_reg_elastic: RTL and testbench

PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

---
 rtl/pipe_reg_elastic.sv | 146 ++++++++++++++
 tb/tb_pipe_reg_elastic.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_elastic
//  Description : Two-entry elastic pipeline register (main + skid) carrying
//                {pc, instr}, with hazard hold, branch flush and an optional
//                stall-cycle counter enabled by PIPE_REG_ELASTIC_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic #(
  parameter int unsigned           PC_W      = 32,
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     NOP_INSTR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [31:0]       stall_cnt_o
);

  // Encoding equals occupancy so count_o is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_main_pc,    w_main_pc_nxt;
  logic [DATA_W-1:0]   r_main_instr, w_main_instr_nxt;
  logic [PC_W-1:0]     r_skid_pc,    w_skid_pc_nxt;
  logic [DATA_W-1:0]   r_skid_instr, w_skid_instr_nxt;
  logic                w_accept;
  logic                w_consume;

  assign in_ready_o  = (r_state != TWO) && !hold_i;
  assign out_valid_o = (r_state != EMPTY) && !hold_i;
  assign pc_o        = r_main_pc;
  assign instr_o     = r_main_instr;
  assign count_o     = r_state;

  assign w_accept  = in_valid_i && in_ready_o && !flush_i;
  assign w_consume = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_pc    <= w_main_pc_nxt;
      r_main_instr <= w_main_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
    end
  end

  // Main register is forced back to {0, NOP} whenever the stage empties so
  // the outputs read as a bubble without extra muxing.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_pc_nxt    = r_main_pc;
    w_main_instr_nxt = r_main_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    if (flush_i) begin
      w_state_nxt      = EMPTY;
      w_main_pc_nxt    = '0;
      w_main_instr_nxt = NOP_INSTR;
      w_skid_pc_nxt    = '0;
      w_skid_instr_nxt = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt      = ONE;
            w_main_pc_nxt    = pc_i;
            w_main_instr_nxt = instr_i;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_pc_nxt    = pc_i;
            w_main_instr_nxt = instr_i;
          end else if (w_accept) begin
            w_state_nxt      = TWO;
            w_skid_pc_nxt    = pc_i;
            w_skid_instr_nxt = instr_i;
          end else if (w_consume) begin
            w_state_nxt      = EMPTY;
            w_main_pc_nxt    = '0;
            w_main_instr_nxt = NOP_INSTR;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_state_nxt      = ONE;
            w_main_pc_nxt    = r_skid_pc;
            w_main_instr_nxt = r_skid_instr;
            w_skid_pc_nxt    = '0;
            w_skid_instr_nxt = '0;
          end
        end
        default: begin
          w_state_nxt      = EMPTY;
          w_main_pc_nxt    = '0;
          w_main_instr_nxt = NOP_INSTR;
        end
      endcase
    end
  end

`ifdef PIPE_REG_ELASTIC_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state != EMPTY) && (hold_i || !out_ready_i) &&
                 (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_elastic
//  Description : Self-checking bench for pipe_reg_elastic: queue-based model
//                compared every cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_elastic;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, hold, flush;
  logic [31:0] pc_in, instr_in, pc_out, instr_out, stall_cnt;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  pipe_reg_elastic #(.PC_W(32), .DATA_W(32), .NOP_INSTR(C_NOP)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc_in), .instr_i(instr_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out), .instr_o(instr_out),
    .hold_i(hold), .flush_i(flush), .count_o(count), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       mq[$];
  int unsigned m_stall;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of at most two beats updated by the handshake rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else if (flush) begin
      mq.delete();
      m_stall = 0;
    end else begin
      bit acc, con;
      int n;
      n   = mq.size();
      acc = in_valid && (n < 2) && !hold;
      con = (n > 0) && !hold && out_ready;
`ifdef PIPE_REG_ELASTIC_PERF_EN
      if ((n > 0) && (hold || !out_ready) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
`endif
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc_in, instr: instr_in});
    end
  end

  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("count",     {62'd0, count},     64'(n));
    chk("in_ready",  {63'd0, in_ready},  64'((n < 2) && !hold));
    chk("out_valid", {63'd0, out_valid}, 64'((n > 0) && !hold));
    chk("pc_o",      {32'd0, pc_out},    {32'd0, (n > 0) ? mq[0].pc : 32'd0});
    chk("instr_o",   {32'd0, instr_out}, {32'd0, (n > 0) ? mq[0].instr : C_NOP});
    chk("stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
  end

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    pc_in    = pc;
    instr_in = instr_of(pc);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(input logic [31:0] pc0, input logic [31:0] pc1);
    out_ready = 1'b0;
    drive(1'b1, pc0);
    next_edge();
    drive(1'b1, pc1);
    next_edge();
    drive(1'b0, 32'd0);
  endtask

  initial begin
    int max_cnt;
    rst = 1'b1; hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_instr", {32'd0, instr_out}, {32'd0, C_NOP});
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming
    max_cnt = 0;
    drive(1'b1, 32'h0);
    next_edge(); drive(1'b1, 32'h4);
    @(negedge clk); chk("str_pc0", {32'd0, pc_out}, 64'h0); chk("str_v0", {63'd0, out_valid}, 64'd1);
    if (count > max_cnt) max_cnt = count;
    next_edge(); drive(1'b1, 32'h8);
    @(negedge clk); chk("str_pc1", {32'd0, pc_out}, 64'h4);
    if (count > max_cnt) max_cnt = count;
    next_edge(); drive(1'b0, 32'h0);
    @(negedge clk); chk("str_pc2", {32'd0, pc_out}, 64'h8); chk("str_in2", {32'd0, instr_out}, 64'hC0DE_0008);
    if (count > max_cnt) max_cnt = count;
    chk("str_maxcnt", 64'(max_cnt), 64'd1);
    next_edge();
    @(negedge clk); chk("str_empty", {62'd0, count}, 64'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h10); next_edge();
    drive(1'b1, 32'h14); next_edge();
    drive(1'b1, 32'h18);
    @(negedge clk);
    chk("bp_count", {62'd0, count}, 64'd2); chk("bp_rdy", {63'd0, in_ready}, 64'd0);
    chk("bp_pc", {32'd0, pc_out}, 64'h10);
    next_edge(); out_ready = 1'b1;
    next_edge();
    @(negedge clk); chk("bp_pc14", {32'd0, pc_out}, 64'h14); chk("bp_cnt1", {62'd0, count}, 64'd1);
    next_edge(); drive(1'b0, 32'h0);
    @(negedge clk); chk("bp_pc18", {32'd0, pc_out}, 64'h18);
    next_edge();

    // Hold
    fill_two(32'h20, 32'h24);
    out_ready = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd0);
      chk("hold_rdy", {63'd0, in_ready}, 64'd0);
      chk("hold_cnt", {62'd0, count}, 64'd2);
      next_edge();
    end
    hold = 1'b0;
    @(negedge clk); chk("hold_pc20", {32'd0, pc_out}, 64'h20);
    next_edge();
    @(negedge clk); chk("hold_pc24", {32'd0, pc_out}, 64'h24);
    next_edge();

    // Flush beats hold and the offered beat
    fill_two(32'h30, 32'h34);
    drive(1'b1, 32'h38); hold = 1'b1; flush = 1'b1;
    next_edge();
    flush = 1'b0; hold = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b1;
    @(negedge clk);
    chk("fl_cnt", {62'd0, count}, 64'd0); chk("fl_pc", {32'd0, pc_out}, 64'h0);
    chk("fl_instr", {32'd0, instr_out}, {32'd0, C_NOP});
    next_edge();
    @(negedge clk); chk("fl_absent", {63'd0, out_valid}, 64'd0);

    // Async reset mid-cycle with two beats held
    @(posedge clk); #1;
    fill_two(32'h40, 32'h44);
    #1; rst = 1'b1;
    #1;
    chk("ar_cnt", {62'd0, count}, 64'd0); chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_pc", {32'd0, pc_out}, 64'h0); chk("ar_instr", {32'd0, instr_out}, {32'd0, C_NOP});
    chk("ar_stall", {32'd0, stall_cnt}, 64'd0);
    #1; rst = 1'b0;

    // Stall counter: five backpressured cycles in ONE
    @(posedge clk); #1;
    out_ready = 1'b0; drive(1'b1, 32'h50);
    next_edge(); drive(1'b0, 32'h0);
    repeat (5) next_edge();
    @(negedge clk);
`ifdef PIPE_REG_ELASTIC_PERF_EN
    chk("stall5", {32'd0, stall_cnt}, 64'd5);
`else
    chk("stall5", {32'd0, stall_cnt}, 64'd0);
`endif
    next_edge(); out_ready = 1'b1;
    next_edge();
    @(negedge clk); chk("end_empty", {62'd0, count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
